// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package wb_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned MAX_SRC    = 4;
  localparam int unsigned SEL_W      = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin winner: first set bit of req_mask at or after ptr, modulo n.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [MAX_SRC-1:0] req_mask,
                                               input logic [SEL_W-1:0]   ptr,
                                               input int unsigned        n);
    logic [SEL_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && req_mask[idx[SEL_W-1:0]]) begin
        win   = idx[SEL_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source writeback request FIFO; exposes per-entry valid/address for hazard lookup.
module wb_req_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_req_t                       push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output wb_req_t                       head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]   ent_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      off          = PTR_W'(PTR_W'(j) - rd_ptr);
      ent_valid[j] = ({1'b0, off} < count);
      ent_addr[j*REG_ADDR_W +: REG_ADDR_W] = mem[j].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_SRC writeback FIFOs onto the single register-file write port.
// Define WB_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC*REG_DATA_W-1:0]  src_data,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_waddr,
  output logic [REG_DATA_W-1:0]          rf_wdata,
  input  logic [REG_ADDR_W-1:0]          query_addr_1,
  input  logic [REG_ADDR_W-1:0]          query_addr_2,
  output logic                           query_pending_1,
  output logic                           query_pending_2,
  output logic                           busy
);

  localparam int unsigned SRC_W = (NUM_SRC > 2) ? 2 : 1;

  logic [NUM_SRC-1:0]               full;
  logic [NUM_SRC-1:0]               empty;
  logic [NUM_SRC-1:0]               push;
  logic [NUM_SRC-1:0]               pop;
  wb_req_t                          push_req  [NUM_SRC];
  wb_req_t                          head      [NUM_SRC];
  logic [FIFO_DEPTH-1:0]            ent_valid [NUM_SRC];
  logic [FIFO_DEPTH*REG_ADDR_W-1:0] ent_addr  [NUM_SRC];
  logic                             grant_c;
  logic [SRC_W-1:0]                 win_c;

  assign src_ready = rst_n ? ~full : '0;
  assign grant_c   = |(~empty);
  assign busy      = grant_c | rf_we;

  for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_src
    // Writes to x0 are acknowledged but dropped before buffering.
    assign push_req[gi] = {src_addr[gi*REG_ADDR_W +: REG_ADDR_W], src_data[gi*REG_DATA_W +: REG_DATA_W]};
    assign push[gi]     = src_valid[gi] && src_ready[gi] && (src_addr[gi*REG_ADDR_W +: REG_ADDR_W] != '0);
    assign pop[gi]      = grant_c && (win_c == SRC_W'(gi));

    wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[gi]),
      .push_data (push_req[gi]),
      .pop       (pop[gi]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head      (head[gi]),
      .ent_valid (ent_valid[gi]),
      .ent_addr  (ent_addr[gi])
    );
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    win_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (!empty[i]) win_c = SRC_W'(i);
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;

  assign win_c = SRC_W'(rr_pick(MAX_SRC'(~empty), SEL_W'(rr_ptr), NUM_SRC));

  // Pointer moves to the source after the winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_c) begin
      rr_ptr <= (win_c == SRC_W'(NUM_SRC - 1)) ? '0 : win_c + SRC_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_c;
      if (grant_c) begin
        rf_waddr <= head[win_c].addr;
        rf_wdata <= head[win_c].data;
      end
    end
  end

  // A write is in flight while buffered or while sitting on the write port.
  always_comb begin
    query_pending_1 = 1'b0;
    query_pending_2 = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
        if (ent_valid[i][j] && (ent_addr[i][j*REG_ADDR_W +: REG_ADDR_W] == query_addr_1)) query_pending_1 = 1'b1;
        if (ent_valid[i][j] && (ent_addr[i][j*REG_ADDR_W +: REG_ADDR_W] == query_addr_2)) query_pending_2 = 1'b1;
      end
    end
    if (rf_we && (rf_waddr == query_addr_1)) query_pending_1 = 1'b1;
    if (rf_we && (rf_waddr == query_addr_2)) query_pending_2 = 1'b1;
    if (query_addr_1 == '0) query_pending_1 = 1'b0;
    if (query_addr_2 == '0) query_pending_2 = 1'b0;
  end

endmodule
